// File: rtl/eeprom_pkg.sv
// eeprom_pkg: definitions shared by the serial EEPROM target and the EEPROM master.
//   - FSM state encoding of the target
//   - control-byte field positions (type [7:4], block [3:1], R/W [0])
//   - bus constants (ACK level, R/W read value, byte length, memory geometry)
package eeprom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_ACK_TX,
    ST_ACK_RX,
    ST_WAIT_STOP
  } state_e;

  localparam logic [3:0]  DEV_TYPE_DEFAULT = 4'b1010;

  localparam int unsigned CTRL_TYPE_MSB = 7;
  localparam int unsigned CTRL_TYPE_LSB = 4;
  localparam int unsigned CTRL_BLK_LSB  = 1;
  localparam int unsigned CTRL_RW_BIT   = 0;

  localparam int unsigned BYTE_BITS      = 8;
  localparam int unsigned EEPROM_MEM_AW  = 11;
  localparam int unsigned EEPROM_PAGE_AW = 4;

  localparam logic I2C_ACK = 1'b0;
  localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: two-flop synchronizers for SCL/SDA plus bus event pulses.
// Ports:
//   CLK, RESET   system clock, synchronous active-high reset
//   scl, sda     raw bus lines
//   sda_s        synchronized SDA
//   scl_rise_c   one-CLK pulse on synchronized SCL rise
//   scl_fall_c   one-CLK pulse on synchronized SCL fall
//   start_c      SDA fall while SCL high
//   stop_c       SDA rise while SCL high
module i2c_line_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_q;
  logic       sda_q;

  // Idle bus level is high, so reset to 1 to avoid phantom edges.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_q  <= scl_ff[1];
      sda_q  <= sda_ff[1];
    end
  end

  assign sda_s      = sda_ff[1];
  assign scl_rise_c =  scl_ff[1] & ~scl_q;
  assign scl_fall_c = ~scl_ff[1] &  scl_q;
  // SCL must be high in both samples so an SCL edge never looks like START/STOP.
  assign start_c    = scl_ff[1] & scl_q &  sda_q & ~sda_ff[1];
  assign stop_c     = scl_ff[1] & scl_q & ~sda_q &  sda_ff[1];

endmodule

// File: rtl/eeprom_slave.sv
// eeprom_slave: I2C target modelling a 24C16-class 2K x 8 serial EEPROM.
// Supports byte/page write, current/random read and sequential read.
// Optional macro EEPROM_SLAVE_WP_EN adds the WP (write protect) input.
// Ports:
//   CLK, RESET  system clock, synchronous active-high reset
//   SCL         serial clock from the master
//   WP          write protect (only with EEPROM_SLAVE_WP_EN)
//   SDA         open-drain serial data (drives 0 or Z)
//   BUSY        high while this target is addressed
module eeprom_slave
  import eeprom_pkg::*;
#(
  parameter int unsigned MEM_AW   = EEPROM_MEM_AW,
  parameter int unsigned PAGE_AW  = EEPROM_PAGE_AW,
  parameter logic [3:0]  DEV_TYPE = DEV_TYPE_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SCL,
`ifdef EEPROM_SLAVE_WP_EN
  input  logic WP,
`endif
  inout  wire  SDA,
  output logic BUSY
);

  // Block-select bits carried in the control byte (3 for a 2K part).
  localparam int unsigned BLK_W = MEM_AW - BYTE_BITS;

  state_e              st;
  state_e              ack_next;
  logic                ack_rise;
  logic                ack_ok;
  logic [3:0]          bit_cnt;
  logic [7:0]          shreg;
  logic [MEM_AW-1:0]   pointer;
  logic                sda_low;
  logic                busy;

  logic                sda_s;
  logic                scl_rise_c;
  logic                scl_fall_c;
  logic                start_c;
  logic                stop_c;
  logic                wp_c;
  logic [7:0]          rx_byte_c;
  logic [7:0]          rd_data_c;
  logic [MEM_AW-1:0]   page_inc_c;
  logic                byte_done_c;
  logic                mem_we_c;

  logic [7:0]          mem [0:(1 << MEM_AW) - 1];

  i2c_line_sync u_sync (
    .CLK        (CLK),
    .RESET      (RESET),
    .scl        (SCL),
    .sda        (SDA),
    .sda_s      (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

`ifdef EEPROM_SLAVE_WP_EN
  assign wp_c = WP;
`else
  assign wp_c = 1'b0;
`endif

  assign SDA  = sda_low ? 1'b0 : 1'bz;
  assign BUSY = busy;

  assign rx_byte_c   = {shreg[6:0], sda_s};
  assign rd_data_c   = mem[pointer];
  assign byte_done_c = scl_rise_c && (bit_cnt == 4'(BYTE_BITS - 1));
  // Write-pointer advance stays inside the current page.
  assign page_inc_c  = {pointer[MEM_AW-1:PAGE_AW], PAGE_AW'(pointer[PAGE_AW-1:0] + 1'b1)};

  // One-CLK write strobe on the 8th rise of a data byte.
  assign mem_we_c = (st == ST_WDATA) && byte_done_c && !start_c && !stop_c
                    && !wp_c && !RESET;

  // Storage is not reset.
  always_ff @(posedge CLK) begin
    if (mem_we_c) mem[pointer] <= rx_byte_c;
  end

  // Protocol FSM; STOP beats START beats bit events.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st       <= ST_IDLE;
      ack_next <= ST_IDLE;
      ack_rise <= 1'b0;
      ack_ok   <= 1'b0;
      bit_cnt  <= 4'd0;
      shreg    <= 8'd0;
      pointer  <= '0;
      sda_low  <= 1'b0;
      busy     <= 1'b0;
    end else if (stop_c) begin
      st       <= ST_IDLE;
      bit_cnt  <= 4'd0;
      ack_rise <= 1'b0;
      sda_low  <= 1'b0;
      busy     <= 1'b0;
    end else if (start_c) begin
      // Repeated START keeps the pointer so a random read can follow.
      st       <= ST_CTRL;
      bit_cnt  <= 4'd0;
      ack_rise <= 1'b0;
      sda_low  <= 1'b0;
    end else begin
      unique case (st)
        ST_CTRL, ST_ADDR, ST_WDATA: begin
          if (scl_rise_c) begin
            shreg <= rx_byte_c;
            if (bit_cnt == 4'(BYTE_BITS - 1)) begin
              bit_cnt  <= 4'(BYTE_BITS);
              ack_rise <= 1'b0;
              if (st == ST_CTRL) begin
                if (rx_byte_c[CTRL_TYPE_MSB:CTRL_TYPE_LSB] == DEV_TYPE) begin
                  pointer[MEM_AW-1:BYTE_BITS] <= rx_byte_c[CTRL_BLK_LSB +: BLK_W];
                  busy     <= 1'b1;
                  ack_ok   <= 1'b1;
                  st       <= ST_ACK_TX;
                  ack_next <= (rx_byte_c[CTRL_RW_BIT] == RW_READ) ? ST_RDATA : ST_ADDR;
                end else begin
                  busy <= 1'b0;
                  st   <= ST_WAIT_STOP;
                end
              end else if (st == ST_ADDR) begin
                pointer[BYTE_BITS-1:0] <= rx_byte_c;
                ack_ok   <= 1'b1;
                st       <= ST_ACK_TX;
                ack_next <= ST_WDATA;
              end else begin
                // Protected bytes are NACKed but still advance the pointer.
                pointer  <= page_inc_c;
                ack_ok   <= !wp_c;
                st       <= ST_ACK_TX;
                ack_next <= ST_WDATA;
              end
            end else begin
              bit_cnt <= 4'(bit_cnt + 1'b1);
            end
          end
        end

        // First fall drives the ACK, the fall after the 9th rise ends it.
        ST_ACK_TX: begin
          if (scl_rise_c) begin
            ack_rise <= 1'b1;
          end else if (scl_fall_c) begin
            if (!ack_rise) begin
              sda_low <= ack_ok;
            end else begin
              ack_rise <= 1'b0;
              bit_cnt  <= 4'd0;
              st       <= ack_next;
              if (ack_next == ST_RDATA) begin
                shreg   <= rd_data_c;
                sda_low <= ~rd_data_c[7];
              end else begin
                sda_low <= 1'b0;
              end
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise_c) begin
            if (bit_cnt == 4'(BYTE_BITS - 1)) begin
              bit_cnt  <= 4'(BYTE_BITS);
              ack_rise <= 1'b0;
              st       <= ST_ACK_RX;
            end else begin
              bit_cnt <= 4'(bit_cnt + 1'b1);
            end
          end else if (scl_fall_c) begin
            shreg   <= {shreg[6:0], 1'b0};
            sda_low <= ~shreg[6];
          end
        end

        // Release for the master's ACK; on ACK reload on the next fall.
        ST_ACK_RX: begin
          if (scl_rise_c) begin
            if (sda_s == I2C_ACK) begin
              pointer  <= MEM_AW'(pointer + 1'b1);
              ack_rise <= 1'b1;
            end else begin
              busy <= 1'b0;
              st   <= ST_WAIT_STOP;
            end
          end else if (scl_fall_c) begin
            if (!ack_rise) begin
              sda_low <= 1'b0;
            end else begin
              ack_rise <= 1'b0;
              bit_cnt  <= 4'd0;
              st       <= ST_RDATA;
              shreg    <= rd_data_c;
              sda_low  <= ~rd_data_c[7];
            end
          end
        end

        default: begin
          sda_low <= 1'b0;
        end
      endcase
    end
  end

endmodule
